// File: rtl/cipher_pkg.sv
// Shared types and rotate helpers for the rotate-cipher FIFO.
// Optional build macro: CIPHER_XOR_EN (adds an XOR mask stage).
package cipher_pkg;

    typedef enum logic {
        CIPHER_ENC = 1'b0,
        CIPHER_DEC = 1'b1
    } cipher_mode_e;

    // Helpers work on a fixed wide container; callers pass the live width.
    localparam int unsigned CIPHER_MAX_W = 64;
    localparam int unsigned CIPHER_IDX_W = 6;

    typedef logic [CIPHER_MAX_W-1:0] cipher_word_t;

    // Rotate the low w bits of v left by sh (mod w); upper bits return 0.
    function automatic cipher_word_t rotl(input cipher_word_t v,
                                          input int unsigned  sh,
                                          input int unsigned  w);
        cipher_word_t r;
        int unsigned  s;
        r = '0;
        s = sh % w;
        for (int unsigned i = 0; i < CIPHER_MAX_W; i++) begin
            if (i < w) begin
                r[CIPHER_IDX_W'((i + s) % w)] = v[CIPHER_IDX_W'(i)];
            end
        end
        return r;
    endfunction

    // Right rotation expressed as the complementary left rotation.
    function automatic cipher_word_t rotr(input cipher_word_t v,
                                          input int unsigned  sh,
                                          input int unsigned  w);
        return rotl(v, w - (sh % w), w);
    endfunction

endpackage

// File: rtl/cipher_fifo_if.sv
// Host/link bus of the rotate-cipher FIFO.
// Optional build macro: CIPHER_XOR_EN (adds the mask signal).
interface cipher_fifo_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned BUF_SIZE = 16
) ();
    import cipher_pkg::*;

    logic                          wr_n;
    logic                          rd_n;
    cipher_mode_e                  mode;
    logic [$clog2(WIDTH)-1:0]      key;
    logic [WIDTH-1:0]              din;
    logic                          err_clr;
`ifdef CIPHER_XOR_EN
    logic [WIDTH-1:0]              mask;
`endif
    logic [WIDTH-1:0]              dout;
    logic                          empty;
    logic                          full;
    logic                          almost_full;
    logic [$clog2(BUF_SIZE+1)-1:0] count;
    logic                          overflow;
    logic                          underflow;

    modport master (
        output wr_n, rd_n, mode, key, din, err_clr,
`ifdef CIPHER_XOR_EN
        output mask,
`endif
        input  dout, empty, full, almost_full, count, overflow, underflow
    );

    modport slave (
        input  wr_n, rd_n, mode, key, din, err_clr,
`ifdef CIPHER_XOR_EN
        input  mask,
`endif
        output dout, empty, full, almost_full, count, overflow, underflow
    );

endinterface

// File: rtl/cipher_rotator.sv
// Combinational write-path transform: rotl for encrypt, rotr for decrypt.
// Optional build macro: CIPHER_XOR_EN (mask applied after rotl on encrypt,
// before rotr on decrypt, so the two directions invert each other).
module cipher_rotator
    import cipher_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned KEY_W = $clog2(WIDTH)
) (
    input  cipher_mode_e     mode_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic [WIDTH-1:0] din_i,
`ifdef CIPHER_XOR_EN
    input  logic [WIDTH-1:0] mask_i,
`endif
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] mask_w;
    cipher_word_t     rot_w;

`ifdef CIPHER_XOR_EN
    assign mask_w = mask_i;
`else
    assign mask_w = '0;
`endif

    // Select direction and apply the mask on the correct side of the rotate.
    always_comb begin
        rot_w  = '0;
        dout_o = '0;
        if (mode_i == CIPHER_ENC) begin
            rot_w  = rotl(CIPHER_MAX_W'(din_i), 32'(key_i), WIDTH);
            dout_o = rot_w[WIDTH-1:0] ^ mask_w;
        end else begin
            rot_w  = rotr(CIPHER_MAX_W'(din_i ^ mask_w), 32'(key_i), WIDTH);
            dout_o = rot_w[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/cipher_fifo.sv
// Rotate-cipher FIFO: each accepted write stores a key/mode-transformed
// word; reads return entries in order through a registered dout.
// Optional build macro: CIPHER_XOR_EN (adds mask to the bus and rotator).
module cipher_fifo
    import cipher_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BUF_SIZE  = 16,
    parameter int unsigned AF_MARGIN = 2
) (
    input logic          clk,
    input logic          reset_n,
    cipher_fifo_if.slave bus
);

    localparam int unsigned KEY_W = $clog2(WIDTH);
    localparam int unsigned PTR_W = $clog2(BUF_SIZE);
    localparam int unsigned CNT_W = $clog2(BUF_SIZE + 1);
    localparam int unsigned AF_TH = (AF_MARGIN >= BUF_SIZE) ? 0 : BUF_SIZE - AF_MARGIN;

    logic [WIDTH-1:0] mem_q [BUF_SIZE];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             af_q, af_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] wdata;
    logic             wr_acc;
    logic             rd_acc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    cipher_rotator #(
        .WIDTH (WIDTH),
        .KEY_W (KEY_W)
    ) u_rot (
        .mode_i (bus.mode),
        .key_i  (bus.key),
        .din_i  (bus.din),
`ifdef CIPHER_XOR_EN
        .mask_i (bus.mask),
`endif
        .dout_o (wdata)
    );

    // Full rejects the write and empty rejects the read independently, which
    // yields read-only at full and write-only at empty for simultaneous requests.
    always_comb begin
        wr_acc  = !bus.wr_n && !full_q;
        rd_acc  = !bus.rd_n && !empty_q;
        wptr_d  = wr_acc ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = rd_acc ? ptr_inc(rptr_q) : rptr_q;
        dout_d  = rd_acc ? mem_q[rptr_q] : dout_q;
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(BUF_SIZE));
        af_d    = (count_d >= CNT_W'(AF_TH));
        ovf_d   = ovf_q;
        if (!bus.wr_n && full_q) begin
            ovf_d = 1'b1;
        end else if (bus.err_clr) begin
            ovf_d = 1'b0;
        end
        udf_d   = udf_q;
        if (!bus.rd_n && empty_q) begin
            udf_d = 1'b1;
        end else if (bus.err_clr) begin
            udf_d = 1'b0;
        end
    end

    // Control and status registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            dout_q  <= dout_d;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.count       = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = udf_q;

endmodule
